// File: rtl/eth_parser_pkg.sv
// L2 parse-path types: header byte array, ethertype, capture FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package eth_parser_pkg;

  localparam int ETH_HDR_BYTES     = 18;
  localparam int ETH_MIN_HDR_BYTES = 14;

  // Byte 0 is the first byte of the frame.
  typedef logic [ETH_HDR_BYTES-1:0][7:0] eth_header_bytes_t;
  typedef logic [15:0]                   ethertype_t;

  localparam ethertype_t ETHERTYPE_VLAN = 16'h8100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2,
    DRAIN   = 2'd3
  } cap_state_e;

endpackage

// File: rtl/eth_header_capture_ctrl_sat_counter.sv
// Saturating event counter; sticks at all-ones.
// Latency: count visible the cycle after inc.
// Backpressure: none.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/eth_header_capture_ctrl.sv
// Captures the first 18 bytes of each frame, presents them until hdr_ready, drains the rest.
// Latency: fields_valid one cycle after the completing byte handshake (18th byte or s_last).
// Backpressure: s_ready low while the header is held; ETH_HDR_CAPTURE_STATS_EN adds frame/runt counters.
module eth_header_capture_ctrl
  import eth_parser_pkg::*;
#(
  parameter int STAT_W        = 16,
  parameter int MIN_HDR_BYTES = ETH_MIN_HDR_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output eth_header_bytes_t header_bytes,
  output ethertype_t        ethertype_raw,
  output logic              fields_valid,
  input  logic              hdr_ready,
  output logic [4:0]        byte_count,
  output logic              runt_err
`ifdef ETH_HDR_CAPTURE_STATS_EN
  ,
  output logic [STAT_W-1:0] frame_cnt,
  output logic [STAT_W-1:0] runt_cnt
`endif
);

  localparam logic [4:0] HDR_CNT  = 5'(ETH_HDR_BYTES);
  localparam logic [4:0] LAST_IDX = 5'(ETH_HDR_BYTES - 1);
  localparam logic [4:0] ET_CNT   = 5'(ETH_MIN_HDR_BYTES);
  localparam logic [4:0] MIN_CNT  = 5'(MIN_HDR_BYTES);

  cap_state_e        state_q, state_nxt;
  logic              ended_q, ended_nxt;
  eth_header_bytes_t hb_nxt;
  logic [4:0]        cnt_nxt;
  ethertype_t        et_nxt;
  logic              runt_nxt;
  logic              accept;

  // s_ready is the only unregistered output; forced low while in reset.
  assign s_ready = rst_n && (state_q != HOLD);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ended_q       <= 1'b0;
      header_bytes  <= '0;
      byte_count    <= '0;
      ethertype_raw <= '0;
      runt_err      <= 1'b0;
      fields_valid  <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      ended_q       <= ended_nxt;
      header_bytes  <= hb_nxt;
      byte_count    <= cnt_nxt;
      ethertype_raw <= et_nxt;
      runt_err      <= runt_nxt;
      fields_valid  <= (state_nxt == HOLD);
    end
  end

  always_comb begin
    state_nxt = state_q;
    ended_nxt = ended_q;
    hb_nxt    = header_bytes;
    cnt_nxt   = byte_count;
    case (state_q)
      IDLE: begin
        if (accept) begin
          hb_nxt    = '0;
          hb_nxt[0] = s_data;
          cnt_nxt   = 5'd1;
          if (s_last) begin
            state_nxt = HOLD;
            ended_nxt = 1'b1;
          end else begin
            state_nxt = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (accept && (byte_count < HDR_CNT)) begin
          hb_nxt[byte_count] = s_data;
          cnt_nxt            = byte_count + 5'd1;
          if (byte_count == LAST_IDX) begin
            state_nxt = HOLD;
            ended_nxt = s_last;
          end else if (s_last) begin
            state_nxt = HOLD;
            ended_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        if (hdr_ready) begin
          state_nxt = ended_q ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (accept && s_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Derived fields track the next header image so they are registered alongside it.
  always_comb begin
    et_nxt   = (cnt_nxt >= ET_CNT) ? {hb_nxt[12], hb_nxt[13]} : '0;
    runt_nxt = (cnt_nxt < MIN_CNT) ||
               ((et_nxt == ETHERTYPE_VLAN) && (cnt_nxt < HDR_CNT));
  end

`ifdef ETH_HDR_CAPTURE_STATS_EN
  logic hold_exit;
  assign hold_exit = (state_q == HOLD) && hdr_ready;

  sat_counter #(.W(STAT_W)) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hold_exit),
    .cnt   (frame_cnt)
  );

  sat_counter #(.W(STAT_W)) u_runt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hold_exit && runt_err),
    .cnt   (runt_cnt)
  );
`endif

endmodule

// File: doc/eth_header_capture_ctrl.md
Name: eth_header_capture_ctrl

Overview:
- Sequences the L2 parse path: accepts an 8-bit byte stream, captures the first ETH_HDR_BYTES (18) bytes of each frame, and presents them to the VLAN resolver.
- Drives the header bytes, raw ethertype and fields_valid.
- Holds them stable until downstream accepts, then drains the frame's remaining bytes.
- Flags runt/truncated headers.

Parameters:
- STAT_W, 16, width of statistics counters (used only with the optional feature).
- MIN_HDR_BYTES, 14, minimum bytes for a valid untagged header.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input byte valid
- s_data  in  8  input byte
- s_last  in  1  final byte of frame
- s_ready  out  1  input byte accepted when s_valid && s_ready
- header_bytes  out  eth_header_bytes_t  captured header, byte 0 = first frame byte
- ethertype_raw  out  16  {header_bytes[12], header_bytes[13]}, or 0 when fewer than 14 bytes captured
- fields_valid  out  1  header presented; held until hdr_ready
- hdr_ready  in  1  downstream consumes header
- byte_count  out  5  number of header bytes captured (0..18)
- runt_err  out  1  header incomplete; qualified by fields_valid

Behaviour:
- Reset (async assert, sync-to-clk release): state IDLE; header_bytes all 0x00; ethertype_raw 0; fields_valid 0; byte_count 0; runt_err 0; s_ready 0 while rst_n low.
- States: IDLE, CAPTURE, HOLD, DRAIN.
- s_ready = 1 in IDLE, CAPTURE and DRAIN; 0 in HOLD.
- IDLE:
  - First accepted byte is written to header_bytes[0]; bytes 1..17 are cleared to 0x00 in the same cycle; byte_count = 1.
  - If s_last: go to HOLD with ended=1; else go to CAPTURE.
- CAPTURE:
  - Each accepted byte is written to header_bytes[byte_count]; byte_count increments.
  - If s_last is seen before index 17: go to HOLD with ended=1.
  - On the accept that writes index 17: go to HOLD with ended = s_last.
  - Bytes are never written beyond index 17.
- HOLD:
  - fields_valid = 1; header_bytes, ethertype_raw, byte_count and runt_err are stable.
  - runt_err = (byte_count < MIN_HDR_BYTES) OR (ethertype_raw == ETHERTYPE_VLAN AND byte_count < 18).
  - On hdr_ready: fields_valid drops next cycle; go to IDLE if ended, else DRAIN.
- DRAIN: accept and discard bytes; on an accepted s_last byte, go to IDLE.
- Latency: fields_valid rises the cycle after the completing byte handshake (18th byte, or the s_last byte).
- Frame turnaround: minimum one s_ready=0 cycle between frames (the HOLD exit cycle).
- All outputs except s_ready are registered; s_ready is decoded from state.
- s_valid low mid-frame: no state change, no writes.
- A 1-byte frame (s_last on the first byte) is legal: HOLD with byte_count=1, runt_err=1, ethertype_raw=0.
- Exactly 18-byte frame: s_last on index 17 sets ended=1, so DRAIN is skipped.
- hdr_ready asserted outside HOLD is ignored.
- Reset mid-frame: partial frame discarded; after release, the next accepted byte is treated as byte 0.

Optional Feature:
- Macro ETH_HDR_CAPTURE_STATS_EN.
- Defined: adds outputs frame_cnt [STAT_W-1:0] and runt_cnt [STAT_W-1:0], both reset to 0.
  - frame_cnt increments on each HOLD exit.
  - runt_cnt increments on each HOLD exit with runt_err=1.
  - Both saturate at all-ones.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- eth_parser_pkg: existing eth_header_bytes_t, ethertype_t and ETHERTYPE_VLAN, plus new ETH_HDR_BYTES=18, ETH_MIN_HDR_BYTES=14 and the cap_state_e enum (IDLE, CAPTURE, HOLD, DRAIN).
- Single module; the stats counters go in a small sub-module sat_counter, instantiated twice under the macro.

Test Plan:
- 64-byte untagged frame, ethertype 0x0800, back-to-back valid → fields_valid one cycle after byte 17; ethertype_raw=0x0800; byte_count=18; runt_err=0; remaining 46 bytes drained; s_ready=0 only during HOLD.
- 64-byte tagged frame, bytes 12–17 = 81 00 A0 64 08 06 → ethertype_raw=0x8100; header_bytes[14]=0xA0, [15]=0x64; runt_err=0.
- 10-byte frame → HOLD with byte_count=10, ethertype_raw=0, runt_err=1, bytes 10..17 = 0x00; hdr_ready → IDLE with no DRAIN.
- 16-byte frame with ethertype 0x8100 → runt_err=1. 18-byte frame with s_last on byte 17 → IDLE directly after hdr_ready.
- hdr_ready held low 20 cycles with s_valid high → s_ready=0 and outputs stable throughout. Random s_valid gaps → captured bytes match the sent bytes.
- rst_n pulsed low at byte 7, then a full frame sent → clean capture of the new frame. With ETH_HDR_CAPTURE_STATS_EN: 3 frames, 1 runt → frame_cnt=3, runt_cnt=1.
